// File: rtl/top_mul_arb_pkg.sv
// ============================================================================
// Module      : top_mul_arb_pkg
// Description : Shared widths, pipeline stage record and exact-product helper
//               for the round-robin multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package top_mul_arb_pkg;

    localparam int A_W      = 8;
    localparam int B_W      = 20;
    localparam int P_W      = 28;
    // Widest requester index (NUM_REQ up to 16); narrower tops use the low bits.
    localparam int ID_MAX_W = 4;

    typedef struct packed {
        logic                  vld;
        logic [ID_MAX_W-1:0]   id;
        logic signed [P_W-1:0] p;
    } stage_t;

    // Unsigned-8 x signed-20 product, exact in 28 bits.
    function automatic logic signed [P_W-1:0] mul_exact(
        input logic [A_W-1:0]        a,
        input logic signed [B_W-1:0] b
    );
        return P_W'($signed({1'b0, a})) * P_W'(b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/top_mul_arb_rr_pick.sv
// ============================================================================
// Module      : top_mul_arb_rr_pick
// Description : Combinational cyclic priority picker: first valid index at or
//               after ptr, wrapping around NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_mul_arb_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               any_req
);

    int w_idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req_vld[w_idx[ID_W-1:0]]) begin
                grant   = w_idx[ID_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/top_mul_arb_rr.sv
// ============================================================================
// Module      : top_mul_arb_rr
// Description : Round-robin arbiter sharing one 8x20 multiplier among NUM_REQ
//               requesters through a LATENCY-stage stallable pipeline.
//               Optional counters: define TOP_MUL_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_mul_arb_rr
    import top_mul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = 3,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_vld,
    output logic [NUM_REQ-1:0]     req_rdy,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_vld,
    input  logic                   res_rdy,
    output logic [ID_W-1:0]        res_id,
    output logic signed [P_W-1:0]  res_p
`ifdef TOP_MUL_ARB_PERF_EN
    ,
    output logic [31:0]            perf_busy_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    stage_t                r_stage_q [LATENCY];
    stage_t                w_stage_d [LATENCY];
    logic [ID_W-1:0]       r_ptr_q;
    logic [ID_W-1:0]       w_ptr_d;
    logic [ID_W-1:0]       w_grant;
    logic                  w_any;
    logic                  w_last_vld;
    logic                  w_adv;
    logic                  w_xfer;
    logic [A_W-1:0]        w_a;
    logic signed [B_W-1:0] w_b;
    logic signed [P_W-1:0] w_prod;
    logic                  w_unused_id;

    top_mul_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_vld (req_vld),
        .ptr     (r_ptr_q),
        .grant   (w_grant),
        .any_req (w_any)
    );

    assign w_last_vld = r_stage_q[LATENCY-1].vld;
    assign w_adv      = !(w_last_vld && !res_rdy);
    assign w_xfer     = w_any && w_adv && !ap_rst;

    always_comb begin
        req_rdy = '0;
        if (w_any && !ap_rst) begin
            req_rdy[w_grant] = w_adv;
        end
    end

    assign w_a    = req_a[int'(w_grant)*A_W +: A_W];
    assign w_b    = req_b[int'(w_grant)*B_W +: B_W];
    // Kept as a bare multiply so the tools map it onto a DSP slice.
    assign w_prod = P_W'($signed({1'b0, w_a})) * P_W'(w_b);

    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            w_stage_d[k] = r_stage_q[k];
        end
        if (w_adv) begin
            w_stage_d[0].vld = w_xfer;
            w_stage_d[0].id  = w_xfer ? ID_MAX_W'(w_grant) : '0;
            w_stage_d[0].p   = w_xfer ? w_prod : '0;
            for (int k = 1; k < LATENCY; k++) begin
                w_stage_d[k] = r_stage_q[k-1];
            end
        end
    end

    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_xfer) begin
            w_ptr_d = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_ptr_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_stage_q[k] <= '0;
            end
        end else begin
            r_ptr_q <= w_ptr_d;
            for (int k = 0; k < LATENCY; k++) begin
                r_stage_q[k] <= w_stage_d[k];
            end
        end
    end

    assign res_vld     = r_stage_q[LATENCY-1].vld;
    assign res_id      = r_stage_q[LATENCY-1].id[ID_W-1:0];
    assign res_p       = r_stage_q[LATENCY-1].p;
    assign w_unused_id = ^r_stage_q[LATENCY-1].id;

`ifdef TOP_MUL_ARB_PERF_EN
    logic [31:0] r_busy_q;
    logic [31:0] w_busy_d;
    logic [31:0] r_stall_q;
    logic [31:0] w_stall_d;

    // Saturating event counters.
    always_comb begin
        w_busy_d  = r_busy_q;
        w_stall_d = r_stall_q;
        if (w_xfer && (r_busy_q != '1)) begin
            w_busy_d = r_busy_q + 32'd1;
        end
        if (w_last_vld && !res_rdy && (r_stall_q != '1)) begin
            w_stall_d = r_stall_q + 32'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_busy_q  <= '0;
            r_stall_q <= '0;
        end else begin
            r_busy_q  <= w_busy_d;
            r_stall_q <= w_stall_d;
        end
    end

    assign perf_busy_cnt  = r_busy_q;
    assign perf_stall_cnt = r_stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/top_mul_arb_rr.md
# top_mul_arb_rr

Round-robin arbiter and pipeline sequencer that shares one unsigned-8 × signed-20 DSP48 multiplier among NUM_REQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one operand pair per cycle, pushes it through a LATENCY-stage registered multiply pipeline, and returns the 28-bit signed product tagged with the requester index. It sits between the HLS-generated filter/convolution loops and the shared multiplier in the recognition datapath.

## Interface
- NUM_REQ, 4: number of requesters; valid range 2–16. ID_W = $clog2(NUM_REQ) is a derived localparam.
- LATENCY, 3: register stages from operand acceptance to result; valid range 1–6.
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- req_vld  in  NUM_REQ  per-requester operand valid.
- req_rdy  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*8  packed unsigned multiplicands; requester i uses bits [8i+7:8i].
- req_b  in  NUM_REQ*20  packed signed multipliers; requester i uses bits [20i+19:20i].
- res_vld  out  1  result valid.
- res_rdy  in  1  result consumer ready.
- res_id  out  ID_W  index of the requester that owns res_p.
- res_p  out  28  signed product $signed({1'b0,a}) * $signed(b).
- perf_busy_cnt  out  32  present only with the perf macro enabled.
- perf_stall_cnt  out  32  present only with the perf macro enabled.

## Operation
- Pipeline: LATENCY stages, each holding {vld, id, p}. Stage 1 captures the full-precision product of the granted pair. Later stages shift it forward. res_* are driven directly from the last stage.
- adv = !(last_vld && !res_rdy). When adv = 0, every stage holds and no grant is issued.
- Arbiter: round-robin pointer ptr (ID_W bits, reset 0).
  - grant = first i ≥ ptr, searching cyclically, with req_vld[i] = 1.
  - req_rdy[grant] = adv; all other req_rdy bits are 0.
- Transfer occurs when req_vld[i] && req_rdy[i]. On a transfer, ptr ← grant+1, wrapping to 0 after NUM_REQ-1. Without a transfer, ptr holds.
- A bubble enters stage 1 when there is no transfer and adv = 1.
- req_rdy may depend combinationally on req_vld and res_rdy. Requesters must not derive req_vld from req_rdy.
- A requester's operands must stay stable while its req_vld is high and no transfer has occurred. The block never drops or reorders an accepted operand pair.
- Results leave in acceptance order. There is no per-requester reordering.
- Arithmetic: a is zero-extended to 9 bits, b is sign-extended, and the product is exact in 28 bits. There is no truncation or saturation.
  - Example: a = 255, b = -524288 gives p = -133693440.

## Timing
- Reset values: res_vld = 0, res_id = 0, res_p = 0, every stage vld = 0, ptr = 0, perf counters = 0. During ap_rst, req_rdy = 0.
- Latency: a pair accepted at edge t appears with res_vld = 1 after edge t+LATENCY, provided no stall occurs in between.
- Throughput: one result per cycle while res_rdy = 1.
- Stall: with res_vld = 1 and res_rdy = 0, all outputs hold and req_rdy = all zeros. The cycle res_rdy returns high, grants resume in that same cycle.
- Reset mid-operation: every in-flight result is discarded. The first grant after reset goes to the lowest active index.
- Simultaneous requests: all requesters are served within NUM_REQ transfers. No requester starves.
- A single active requester receives a transfer every cycle.

## Configuration
- TOP_MUL_ARB_PERF_EN defined:
  - perf_busy_cnt increments on each cycle with a transfer.
  - perf_stall_cnt increments on each cycle with last_vld && !res_rdy.
  - Both counters saturate at 0xFFFFFFFF and clear on ap_rst.
- TOP_MUL_ARB_PERF_EN undefined: both perf ports and their logic are absent. All other behaviour is identical.

## Structure
- Package top_mul_arb_pkg holds:
  - constants A_W = 8, B_W = 20, P_W = 28;
  - a typedef for the stage record {vld, id, p};
  - a function computing the exact product.
- Sub-module top_mul_arb_rr_pick: combinational cyclic priority picker. Inputs are req_vld and ptr; outputs are grant index and any_req.
- The pipeline and ptr update stay in the top module. Stage 1's multiply is written as a plain expression so that synthesis infers a DSP48.

## Test plan
- Single requester, continuous stream: requester 2 streams a = 3, b = -7 every cycle → res_p = -21 and res_id = 2 every cycle, starting LATENCY cycles after the first accept.
- All requesters continuously valid: grants cycle 0,1,2,3,0,… and res_id follows the same order, one result per cycle.
- Extremes: a = 255 with b = 524287, then a = 255 with b = -524288 → res_p = 133693185, then -133693440. Also a = 0, b = -1 → 0.
- Backpressure: hold res_rdy = 0 for 5 cycles mid-stream → res_* stable, req_rdy = 0, no result lost or duplicated. The order is checked against a scoreboard.
- Reset mid-stream: assert ap_rst for 1 cycle with the pipeline full → res_vld = 0 on the next cycle, ptr = 0, and no stale result appears afterwards.
- With TOP_MUL_ARB_PERF_EN: 10 transfers plus 4 stall cycles → perf_busy_cnt = 10 and perf_stall_cnt = 4.
